disp_rd_ctrl_gen: RTL

- Parametrised AXI4 read-address/read-data controller that fetches one frame from VRAM per start pulse and feeds the display FIFO.
- Sits between the AXI HP read port and the pixel FIFO.
- Generalises resolution, pixel size, bus width and burst length.
- Adds a per-frame base address (double buffering), multiple outstanding bursts, abort-with-drain on DISP_ON low, and RRESP error reporting.

---
 rtl/disp_pkg.sv | 18 +
 rtl/disp_rd_ctrl_gen_if.sv | 27 ++
 rtl/sync_rise_det.sv | 23 ++
 rtl/disp_rd_ctrl_gen.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display-path types and constants: FSM state encoding, AXI field values, XGA defaults.
// Latency: none (declarations only).
// Backpressure: not applicable.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } disp_rd_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int XGA_H_VISIBLE = 1024;
    localparam int XGA_V_VISIBLE = 768;

endpackage

// File: rtl/disp_rd_ctrl_gen_if.sv
// AXI4 read-address and read-data channel bundle between the frame fetcher and the HP port.
// Latency: none (wires only).
// Backpressure: ARVALID/ARREADY on the address channel, RVALID/RREADY on the data channel.
interface disp_rd_ctrl_gen_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    logic                  RVALID;
    logic                  RLAST;
    logic [1:0]            RRESP;
    logic                  RREADY;

    modport master (
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RVALID, RLAST, RRESP
    );

    modport slave (
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RVALID, RLAST, RRESP
    );
endinterface

// File: rtl/sync_rise_det.sv
// Three-flop synchroniser for an asynchronous level with a one-cycle rising-edge pulse.
// Latency: input first sampled high at edge k gives rise high after edge k+1.
// Backpressure: none; the pulse is emitted unconditionally.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    // bits [0] and [1] resolve metastability, bit [2] remembers the previous settled level
    logic [2:0] sync_q;

    // shift the asynchronous level through the synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/disp_rd_ctrl_gen.sv
// Fetches one display frame from VRAM per start request as fixed-size INCR bursts.
// Latency: ARVALID rises 3 cycles after AXI_START is first sampled high (FIFO room permitting).
// Backpressure: AR issue gated by FIFO_READY and an outstanding-burst cap; RREADY follows RVALID.
module disp_rd_ctrl_gen
    import disp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int H_VISIBLE       = XGA_H_VISIBLE,
    parameter int V_VISIBLE       = XGA_V_VISIBLE,
    parameter int BYTES_PER_PIXEL = 4,
    parameter int DATA_BYTES      = 8,
    parameter int BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    disp_rd_ctrl_gen_if.master    axi,
    input  logic                  AXI_START,
    input  logic                  DISP_ON,
    input  logic [ADDR_WIDTH-1:0] FRAME_BASE,
    input  logic                  FIFO_READY,
    output logic                  BUSY,
    output logic                  ERR_RESP
);
    localparam int BURST_BYTES = BURST_LEN * DATA_BYTES;
    localparam int FRAME_BYTES = H_VISIBLE * V_VISIBLE * BYTES_PER_PIXEL;
    localparam int N_BURSTS    = FRAME_BYTES / BURST_BYTES;
    localparam int BURST_SHIFT = $clog2(BURST_BYTES);
    localparam int ISSUE_W     = $clog2(N_BURSTS + 1);
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ISSUE_W-1:0]    N_BURSTS_C = ISSUE_W'(N_BURSTS);
    localparam logic [OUT_W-1:0]      MAX_OUT_C  = OUT_W'(MAX_OUTSTANDING);
    // clears the in-burst offset so every burst is naturally aligned
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK  =
        ~((ADDR_WIDTH'(1) << BURST_SHIFT) - ADDR_WIDTH'(1));

    if ((FRAME_BYTES % BURST_BYTES) != 0) begin : g_err_frame
        $error("frame size is not a whole number of bursts");
    end
    if ((4096 % BURST_BYTES) != 0) begin : g_err_4k
        $error("burst size must divide 4096 so no burst crosses a 4KB boundary");
    end
    if ((DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_err_dbytes
        $error("DATA_BYTES must be a power of two");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_err_blen
        $error("BURST_LEN must be 1..256");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_err_maxout
        $error("MAX_OUTSTANDING must be 1..15");
    end

    disp_rd_state_t        state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic [ISSUE_W-1:0]    issued;
    logic [OUT_W-1:0]      outstanding;
    logic                  err_q;

    logic                  start_rise;
    logic                  start;
    logic                  active;
    logic                  ar_hs;
    logic                  r_beat;
    logic                  burst_done;
    logic                  can_issue;
    logic [ADDR_WIDTH-1:0] next_addr;

    sync_rise_det u_start_sync (
        .clk  (ACLK),
        .rst  (ARST),
        .din  (AXI_START),
        .rise (start_rise)
    );

    assign start      = start_rise & DISP_ON;
    assign active     = (state != ST_IDLE);
    assign ar_hs      = arvalid_q & axi.ARREADY;
    assign r_beat     = axi.RVALID & axi.RREADY;
    assign burst_done = r_beat & axi.RLAST;
    // DISP_ON low blocks issue in the same cycle the FSM heads for DRAIN
    assign can_issue  = (state == ST_RUN) && DISP_ON && !arvalid_q && FIFO_READY &&
                        (outstanding < MAX_OUT_C) && (issued < N_BURSTS_C);
    assign next_addr  = base_q + (ADDR_WIDTH'(issued) << BURST_SHIFT);

    // frame FSM with AR issue, outstanding-burst bookkeeping and sticky error flag
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state       <= ST_IDLE;
            base_q      <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            issued      <= '0;
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            // address stays frozen while ARVALID is up; FIFO_READY only matters before issue
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                issued    <= issued + ISSUE_W'(1);
            end else if (can_issue) begin
                arvalid_q <= 1'b1;
                araddr_q  <= next_addr;
            end

            // a burst accepted and one completed in the same cycle cancel out
            if (active) begin
                if (ar_hs && !burst_done) begin
                    outstanding <= outstanding + OUT_W'(1);
                end else if (!ar_hs && burst_done && outstanding != '0) begin
                    outstanding <= outstanding - OUT_W'(1);
                end
            end

            if (active && r_beat && axi.RRESP != AXI_RESP_OKAY) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        base_q      <= FRAME_BASE & BASE_MASK;
                        issued      <= '0;
                        outstanding <= '0;
                        err_q       <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!DISP_ON) begin
                        state <= ST_DRAIN;
                    end else if (issued == N_BURSTS_C && outstanding == '0) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!arvalid_q && outstanding == '0) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assert property (@(posedge ACLK) disable iff (ARST)
        (active && burst_done && !ar_hs) |-> (outstanding != '0))
        else $error("outstanding burst count underflow");

    assert property (@(posedge ACLK) disable iff (ARST)
        outstanding <= MAX_OUT_C)
        else $error("outstanding burst count above limit");

    assign axi.ARADDR  = araddr_q;
    assign axi.ARLEN   = 8'(BURST_LEN - 1);
    assign axi.ARSIZE  = 3'($clog2(DATA_BYTES));
    assign axi.ARBURST = AXI_BURST_INCR;
    assign axi.ARVALID = arvalid_q;
    // stray beats after an abort or reset must never stall the interconnect
    assign axi.RREADY  = axi.RVALID;

    assign BUSY     = active;
    assign ERR_RESP = err_q;
endmodule
